mem_arbiter: RTL and testbench

Two-master arbiter for the multicycle CPU's single memory port. It lets the CPU (master 0) and a DMA/IO engine (master 1) share one synchronous memory. Requesters use a req/ack handshake. The arbiter sequences each granted access through a fixed number of wait cycles and returns read data together with a one-cycle ack. It sits between the CPU's `madr`/`tomem`/`wmem`/`frommem` port and the memory macro.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_rr_pick2.sv | 15 +
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// FSM state encoding and the wait-counter width.
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way winner select. valid=any request; win=index of the winner.
// Ports: req0, req1, last (last served) -> valid, win.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic win
);

  assign valid = req0 | req1;
  // On a tie the master not served last wins; last=1 gives master 0 priority.
  assign win   = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU=m0, DMA=m1) arbiter for one synchronous memory port.
// Ports: clock/resetn; mN_req/we/addr/wdata in, mN_ack/rdata out;
// mem_en/we/addr/wdata out, mem_rdata in; busy, owner status.
// Build option MEM_ARB_FIXED_PRIO_EN: master 0 wins every tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  if (WAIT < 1 || WAIT > 15) begin : g_wait_chk
    $error("mem_arbiter: WAIT must be in 1..15");
  end

  localparam logic [WAIT_W-1:0] CNT_INIT = WAIT_W'(WAIT - 1);
  localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);
  localparam logic              WAIT1    = (WAIT == 1);

  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              owner_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rd0_q;
  logic [DW-1:0]     rd1_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              en_q;
  logic              mwe_q;

  logic              last_w;
  logic              pick_valid;
  logic              pick_win;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last_w = 1'b1;
`else
  logic last_q;
  assign last_w = last_q;
`endif

  rr_pick2 u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (last_w),
    .valid (pick_valid),
    .win   (pick_win)
  );

  assign sel_we    = pick_win ? m1_we    : m0_we;
  assign sel_addr  = pick_win ? m1_addr  : m0_addr;
  assign sel_wdata = pick_win ? m1_wdata : m0_wdata;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      en_q    <= 1'b0;
      mwe_q   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_ACCESS;
            owner_q <= pick_win;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= CNT_INIT;
            en_q    <= 1'b1;
            // A single-cycle access is already the strobe cycle.
            mwe_q   <= sel_we & WAIT1;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            en_q    <= 1'b0;
            mwe_q   <= 1'b0;
            if (owner_q) ack1_q <= 1'b1;
            else         ack0_q <= 1'b1;
            if (!we_q) begin
              if (owner_q) rd1_q <= mem_rdata;
              else         rd0_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            // Strobe only in the cycle where the counter reaches 0.
            mwe_q <= we_q & (cnt_q == CNT_ONE);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_q  <= owner_q;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          en_q    <= 1'b0;
          mwe_q   <= 1'b0;
        end
      endcase
    end
  end

  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign mem_en    = en_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with WAIT=2 and a small memory.
// Each scenario task drives stimulus and checks its own results.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, owner;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  // Memory model with a backdoor port for preloading.
  logic [DW-1:0] mem [0:255];
  logic          bk_we = 1'b0;
  logic [7:0]    bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  always @(posedge clock) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clock);
    bk_we = 1'b0;
  endtask

  task automatic set_m(input bit m, input logic r, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m) begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // One transfer; returns latency in cycles (0 on timeout) and observations.
  task automatic run_xfer(input bit m, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output int nwe,
                          output logic [AW-1:0] wa, output bit oth,
                          output logic [DW-1:0] rd);
    bit done;
    lat = 0; nwe = 0; wa = '0; oth = 1'b0; rd = '0; done = 1'b0;
    @(negedge clock);
    set_m(m, 1'b1, we, a, d);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clock);
      if (mem_en && mem_we) begin nwe++; wa = mem_addr; end
      if (m ? m0_ack : m1_ack) oth = 1'b1;
      if (m ? m1_ack : m0_ack) begin
        lat = c; rd = m ? m1_rdata : m0_rdata; done = 1'b1;
      end
    end
    set_m(m, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, owner, m0_ack, m1_ack, mem_en, mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {busy, owner, m0_ack, m1_ack, mem_en, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    int lat, nwe; logic [AW-1:0] wa; bit oth; logic [DW-1:0] rd;
    run_xfer(1'b0, 1'b0, 32'h10, '0, lat, nwe, wa, oth, rd);
    checks++;
    if (lat !== W + 1) begin
      failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, W + 1);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL read_data got=%h exp=deadbeef", rd);
    end
    checks++;
    if (oth !== 1'b0 || nwe !== 0) begin
      failures++;
      $display("FAIL read_side got m1_ack=%0d we=%0d exp=0/0", oth, nwe);
    end
  endtask

  task automatic test_single_write();
    int lat, nwe; logic [AW-1:0] wa; bit oth; logic [DW-1:0] rd;
    run_xfer(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, lat, nwe, wa, oth, rd);
    checks++;
    if (lat !== W + 1) begin
      failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, W + 1);
    end
    checks++;
    if (nwe !== 1 || wa !== 32'h40) begin
      failures++;
      $display("FAIL write_strobe got n=%0d a=%h exp n=1 a=40", nwe, wa);
    end
    checks++;
    if (oth !== 1'b0) begin
      failures++; $display("FAIL write_m0_ack got=1 exp=0");
    end
    checks++;
    if (m1_rdata !== 32'h0 || m0_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_keeps_rdata got=%h/%h exp=deadbeef/0",
               m0_rdata, m1_rdata);
    end
    run_xfer(1'b0, 1'b0, 32'h40, '0, lat, nwe, wa, oth, rd);
    checks++;
    if (rd !== 32'hA5A5A5A5 || lat !== W + 1) begin
      failures++;
      $display("FAIL write_readback got=%h lat=%0d exp=a5a5a5a5 lat=%0d",
               rd, lat, W + 1);
    end
  endtask

  task automatic test_contention();
    int n, cyc_prev;
    bit who;
    bit exp_who;
    do_reset();
    n = 0; cyc_prev = 0;
    @(negedge clock);
    set_m(1'b0, 1'b1, 1'b0, 32'h10, '0);
    set_m(1'b1, 1'b1, 1'b0, 32'h40, '0);
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clock);
      if (m0_ack || m1_ack) begin
        who = m1_ack;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_who = 1'b0;
`else
        exp_who = n[0];
`endif
        checks++;
        if ((m0_ack && m1_ack) || who !== exp_who) begin
          failures++;
          $display("FAIL contention_order[%0d] got=%0d exp=%0d",
                   n, who, exp_who);
        end
        checks++;
        if (c - cyc_prev !== ((n == 0) ? W + 1 : W + 2)) begin
          failures++;
          $display("FAIL contention_gap[%0d] got=%0d exp=%0d",
                   n, c - cyc_prev, (n == 0) ? W + 1 : W + 2);
        end
        checks++;
        if ((who ? m1_rdata : m0_rdata) !==
            (who ? 32'hA5A5A5A5 : 32'hDEADBEEF)) begin
          failures++;
          $display("FAIL contention_rdata[%0d] got=%h", n,
                   who ? m1_rdata : m0_rdata);
        end
        cyc_prev = c;
        n++;
      end
    end
    set_m(1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL contention_count got=%0d exp=4", n);
    end
    @(negedge clock);
  endtask

  task automatic test_input_change();
    int lat; bit bad;
    logic [AW-1:0] seen;
    lat = 0; bad = 1'b0; seen = '0;
    poke(8'h20, 32'h22222222);
    @(negedge clock);
    set_m(1'b0, 1'b1, 1'b0, 32'h10, '0);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clock);
      if (mem_en && mem_addr !== 32'h10) begin bad = 1'b1; seen = mem_addr; end
      if (c == 1) set_m(1'b0, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF);
      if (m0_ack) lat = c;
    end
    set_m(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (bad) begin
      failures++; $display("FAIL hold_addr got=%h exp=10", seen);
    end
    checks++;
    if (lat !== W + 1 || m0_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL hold_rdata got=%h lat=%0d exp=deadbeef lat=%0d",
               m0_rdata, lat, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nwe; logic [AW-1:0] wa; bit oth; logic [DW-1:0] rd;
    bit bad;
    bad = 1'b0;
    poke(8'h30, 32'h0);
    @(negedge clock);
    set_m(1'b0, 1'b1, 1'b1, 32'h30, 32'h12345678);
    @(negedge clock);
    checks++;
    if (mem_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_access got en=%b busy=%b exp=1/1", mem_en, busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, owner, m0_ack, m1_ack, mem_en, mem_we} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b a=%h d=%h r=%h",
               {busy, owner, m0_ack, m1_ack, mem_en, mem_we},
               mem_addr, mem_wdata, m0_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (m0_ack || mem_we || mem_en) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL rstmid_held got activity exp=none");
    end
    set_m(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    resetn = 1'b1;
    run_xfer(1'b0, 1'b0, 32'h30, '0, lat, nwe, wa, oth, rd);
    checks++;
    if (rd !== 32'h0 || lat !== W + 1) begin
      failures++;
      $display("FAIL rstmid_nowrite got=%h lat=%0d exp=0 lat=%0d",
               rd, lat, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int n, c1, c2;
    logic [DW-1:0] r1, r2;
    n = 0; c1 = 0; c2 = 0; r1 = '0; r2 = '0;
    @(negedge clock);
    set_m(1'b0, 1'b1, 1'b0, 32'h10, '0);
    for (int c = 1; c <= 30 && n < 2; c++) begin
      @(negedge clock);
      if (m0_ack) begin
        if (n == 0) begin c1 = c; r1 = m0_rdata; end
        else begin c2 = c; r2 = m0_rdata; end
        set_m(1'b0, 1'b0, 1'b0, '0, '0);
        n++;
      end else if (n == 1 && c == c1 + 1) begin
        set_m(1'b0, 1'b1, 1'b0, 32'h40, '0);
      end
    end
    set_m(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (n !== 2 || c2 - c1 !== W + 2) begin
      failures++;
      $display("FAIL b2b_gap got n=%0d gap=%0d exp n=2 gap=%0d",
               n, c2 - c1, W + 2);
    end
    checks++;
    if (r1 !== 32'hDEADBEEF || r2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL b2b_rdata got=%h/%h exp=deadbeef/a5a5a5a5", r1, r2);
    end
  endtask

  initial begin
    test_reset();
    poke(8'h10, 32'hDEADBEEF);
    poke(8'h40, 32'h0);
    test_single_read();
    test_single_write();
    test_contention();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
